fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and defaults: queue depth, reset PC and the fetch entry layout.
package riscv_pkg;

    localparam int          FQ_DEPTH    = 4;
    localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch entry FIFO with a registered head; the backing array only holds entries behind the head.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [ENTRY_W-1:0]       head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic [ENTRY_W-1:0] head_reg;

    logic do_push;
    logic do_pop;
    logic head_from_push;
    logic head_from_mem;
    logic mem_write;

    always_comb begin
        do_pop         = pop && (count_reg != '0);
        do_push        = push && ((count_reg != FULL) || do_pop);
        // The head takes the pushed word directly whenever nothing else would be left behind it.
        head_from_push = do_push && ((count_reg == '0) || (do_pop && count_reg == ONE));
        head_from_mem  = do_pop && (count_reg > ONE);
        mem_write      = do_push && !head_from_push;
    end

    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (head_from_push) begin
                head_reg <= push_data;
            end else if (head_from_mem) begin
                head_reg <= mem[rd_ptr_reg];
            end
            if (mem_write) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (head_from_mem) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_valid = (count_reg != '0);
    assign head_data  = head_reg;
    assign count      = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word fetches under queue credit, queues in-order
// responses with their PCs, and drains stale responses after a redirect.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = FQ_DEPTH,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = CW + 1;

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   resp_pc_reg, resp_pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] drop_cnt_reg, drop_cnt_next;

    logic [CW-1:0]      fifo_count;
    logic               fifo_valid;
    logic [ENTRY_W-1:0] head_data;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;

    logic          grant, rsp_stale, rsp_live, push, pop;
    logic          credit_ok, inflight_ok;
    logic [TW-1:0] occupancy, inflight;

    always_comb begin
        occupancy   = TW'(fifo_count) + TW'(outstanding_reg);
        inflight    = TW'(drop_cnt_reg) + TW'(outstanding_reg);
        credit_ok   = occupancy < TW'(DEPTH);
        // Keeps live plus stale requests representable in the counter width across back-to-back redirects.
        inflight_ok = inflight < TW'(2 * DEPTH - 1);
        imem_req    = reset && credit_ok && inflight_ok;
        grant       = imem_req && imem_gnt;
        rsp_stale   = imem_rvalid && (drop_cnt_reg != '0);
        rsp_live    = imem_rvalid && (drop_cnt_reg == '0) && (outstanding_reg != '0);
        push        = rsp_live && !redirect;
        pop         = fifo_valid && out_ready && !redirect;
    end

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg;
        drop_cnt_next    = drop_cnt_reg;
        if (redirect) begin
            fetch_pc_next    = word_align(redirect_pc);
            resp_pc_next     = word_align(redirect_pc);
            outstanding_next = '0;
            drop_cnt_next    = drop_cnt_reg + outstanding_reg + CW'(grant)
                             - CW'(rsp_stale || rsp_live);
        end else begin
            if (grant) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (rsp_live) begin
                resp_pc_next = resp_pc_reg + 32'd4;
            end
            outstanding_next = outstanding_reg + CW'(grant) - CW'(rsp_live);
            drop_cnt_next    = drop_cnt_reg - CW'(rsp_stale);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> (outstanding_reg != '0 || drop_cnt_reg != '0));

    always_comb begin
        push_entry.instr    = imem_rdata;
        push_entry.pc       = resp_pc_reg;
        push_entry.pc_plus4 = resp_pc_reg + 32'd4;
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_valid(fifo_valid),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign head_entry   = head_data;
    assign imem_addr    = fetch_pc_reg;
    assign out_valid    = fifo_valid;
    assign out_instr    = fifo_valid ? head_entry.instr    : 32'h0;
    assign out_pc       = fifo_valid ? head_entry.pc       : 32'h0;
    assign out_pc_plus4 = fifo_valid ? head_entry.pc_plus4 : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a memory model feeds responses, a scoreboard queue holds
// expected entries and an independent monitor checks every pop against it.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_pc, out_pc_plus4;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc_plus4(out_pc_plus4)
    );

    typedef struct { logic [31:0] addr; bit live; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4; } exp_t;

    req_t        pending[$];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    bit          gnt_en, resp_en;
    logic [31:0] model_pc;
    logic        s_req, s_out_valid;
    logic [31:0] s_addr, s_out_pc, s_out_pc4;
    int          cyc, first_valid_cyc, grant_cnt;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive memory inputs, sample DUT at negedge, update model after the edge.
    task automatic step_cycle();
        bit   rv;
        req_t head;
        rv          = resp_en && reset && (pending.size() > 0);
        imem_rvalid = rv;
        imem_rdata  = rv ? instr_of(pending[0].addr) : 32'h0;
        imem_gnt    = gnt_en;
        @(negedge clk);
        s_req       = imem_req;
        s_addr      = imem_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_pc4   = out_pc_plus4;
        cyc++;
        if (reset && s_out_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
        if (reset && s_req) check("fetch_addr", s_addr, model_pc);
        @(posedge clk);
        #1;
        if (!reset) return;
        if (rv) begin
            head = pending.pop_front();
            if (head.live && !redirect)
                exp_q.push_back('{instr_of(head.addr), head.addr, head.addr + 32'd4});
        end
        if (s_req && imem_gnt) begin
            pending.push_back('{s_addr, 1'b1});
            grant_cnt++;
            model_pc = s_addr + 32'd4;
        end
        if (redirect) begin
            foreach (pending[i]) pending[i].live = 1'b0;
            exp_q.delete();
            model_pc = {redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            step_cycle();
            n++;
        end while (!s_out_valid && n < 20);
        if (!s_out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: got no out_valid within 20 cycles, expected out_valid=1", name);
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready && !redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc %h instr %h, expected no entry", out_pc, out_instr);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_instr !== mon_e.instr || out_pc !== mon_e.pc || out_pc_plus4 !== mon_e.pc4) begin
                    errors++;
                    $display("FAIL pop_entry: got instr=%h pc=%h pc4=%h, expected instr=%h pc=%h pc4=%h",
                             out_instr, out_pc, out_pc_plus4, mon_e.instr, mon_e.pc, mon_e.pc4);
                end else begin
                    $display("pop pc=%h instr=%h pc4=%h ok", out_pc, out_instr, out_pc_plus4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gnt_en = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
        model_pc = RESET_PC; cyc = 0; first_valid_cyc = 0; grant_cnt = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_out_valid", out_valid, 0);
        check("rst_instr", out_instr, 0);
        check("rst_pc", out_pc, 0);
        check("rst_pc4", out_pc_plus4, 0);

        // Streaming after release
        reset = 1'b1;
        cyc = 0;
        step_cycle();
        check("req_after_release", s_req, 1);
        repeat (9) step_cycle();
        check("first_valid_cycle", first_valid_cyc, 3);

        // Backpressure: exactly DEPTH grants, then recovery
        gnt_en = 1'b0;
        repeat (6) step_cycle();
        check("drain1_empty", exp_q.size(), 0);
        out_ready = 1'b0; gnt_en = 1'b1; grant_cnt = 0;
        repeat (10) step_cycle();
        check("grants_when_stalled", grant_cnt, DEPTH);
        check("req_low_when_full", imem_req, 0);
        out_ready = 1'b1;
        step_cycle();
        step_cycle();
        check("req_after_pop", s_req, 1);
        repeat (8) step_cycle();

        // Redirect with two outstanding requests
        gnt_en = 1'b0;
        repeat (8) step_cycle();
        resp_en = 1'b0; gnt_en = 1'b1;
        repeat (2) step_cycle();
        check("two_outstanding", pending.size(), 2);
        gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step_cycle();
        redirect = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
        step_cycle();
        check("redir_addr", s_addr, 32'h0000_0100);
        wait_valid("redir_wait");
        check("redir_first_pc", s_out_pc, 32'h0000_0100);

        // Redirect coinciding with grant, response and pop
        repeat (4) step_cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step_cycle();
        redirect = 1'b0;
        check("coinc_out_valid", s_out_valid, 1);
        check("coinc_req", s_req, 1);
        step_cycle();
        check("coinc_flush_valid", s_out_valid, 0);
        check("coinc_addr", s_addr, 32'h0000_0200);

        // Address wrap at the top of the space
        repeat (3) step_cycle();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step_cycle();
        redirect = 1'b0;
        step_cycle();
        check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        step_cycle();
        check("wrap_addr1", s_addr, 32'h0000_0000);
        wait_valid("wrap_wait");
        check("wrap_pc", s_out_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", s_out_pc4, 32'h0000_0000);

        // Reset mid-operation with requests outstanding and entries queued
        out_ready = 1'b0; resp_en = 1'b0; gnt_en = 1'b1;
        repeat (3) step_cycle();
        resp_en = 1'b1;
        step_cycle();
        reset = 1'b0;
        #1;
        check("midrst_req", imem_req, 0);
        check("midrst_addr", imem_addr, RESET_PC);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_instr", out_instr, 0);
        check("midrst_pc", out_pc, 0);
        check("midrst_pc4", out_pc_plus4, 0);
        pending.delete();
        exp_q.delete();
        model_pc = RESET_PC;
        imem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; out_ready = 1'b1; resp_en = 1'b1; gnt_en = 1'b1;
        step_cycle();
        check("restart_req", s_req, 1);
        check("restart_addr", s_addr, RESET_PC);
        repeat (10) step_cycle();

        // Final drain
        gnt_en = 1'b0;
        repeat (8) step_cycle();
        check("final_drain", exp_q.size(), 0);
        check("final_pending", pending.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
